vga_timing_gen: RTL

Generates 640x480@60 Hz VGA raster timing from the 25 MHz pixel clock. Supplies pixel coordinates and the active-video flag to the sprite/background renderers, and drives the monitor sync pins. hs/vs plus a pin-side copy of blank are delayed so they stay aligned with the renderers' registered colour output. Also produces frame and vertical-blank strobes for game-state update logic.

---
 rtl/vga_pkg.sv | 25 ++
 rtl/vga_if.sv | 26 ++
 rtl/sync_delay.sv | 34 +++
 rtl/vga_timing_gen.sv | 116 +++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared timing constants and the sync/blank bundle type for the 640x480@60 raster.
package vga_pkg;
  localparam int H_ACTIVE   = 640;
  localparam int H_FP       = 16;
  localparam int H_SYNC     = 96;
  localparam int H_BP       = 48;
  localparam int H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_ACTIVE   = 480;
  localparam int V_FP       = 10;
  localparam int V_SYNC     = 2;
  localparam int V_BP       = 33;
  localparam int V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int PIPE_DELAY = 2;
  localparam int FC_W       = 8;
  localparam int COORD_W    = 10;

  typedef struct packed {
    logic hs;
    logic vs;
    logic blank;
  } vga_sync_t;

  // Pin levels while idle: both syncs deasserted (active-low), video blanked.
  localparam vga_sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, blank: 1'b0};
endpackage

// File: rtl/vga_if.sv
// Raster outputs of the timing generator: coordinates, video flags, sync pins, strobes.
interface vga_if #(
  parameter int FC_BITS = 8
);
  import vga_pkg::*;

  logic [COORD_W-1:0] DrawX;
  logic [COORD_W-1:0] DrawY;
  logic               blank;
  logic               blank_pin;
  logic               hs;
  logic               vs;
  logic               frame_start;
  logic               vblank_start;
  logic [FC_BITS-1:0] frame_count;

  modport master (
    output DrawX, DrawY, blank, blank_pin, hs, vs,
           frame_start, vblank_start, frame_count
  );

  modport slave (
    input DrawX, DrawY, blank, blank_pin, hs, vs,
          frame_start, vblank_start, frame_count
  );
endinterface

// File: rtl/sync_delay.sv
// Fixed-depth shift register for the sync/blank bundle; depth 0 degenerates to a wire.
module sync_delay import vga_pkg::*; #(
  parameter int        DEPTH   = 2,
  parameter vga_sync_t RST_VAL = SYNC_IDLE
) (
  input  logic      clk,
  input  logic      reset,
  input  vga_sync_t din,
  output vga_sync_t dout
);
  generate
    if (DEPTH == 0) begin : g_wire
      assign dout = din;
    end else begin : g_pipe
      vga_sync_t stage [DEPTH];

      // Shift one stage per clock; reset clears every stage so no stale pulse escapes.
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < DEPTH; i++) begin
            stage[i] <= RST_VAL;
          end
        end else begin
          stage[0] <= din;
          for (int i = 1; i < DEPTH; i++) begin
            stage[i] <= stage[i-1];
          end
        end
      end

      assign dout = stage[DEPTH-1];
    end
  endgenerate
endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing: pixel/line counters, active-video and sync decode, frame/vblank strobes,
// plus a delay line that keeps the sync pins aligned with the renderers' colour output.
module vga_timing_gen #(
  parameter int H_ACTIVE   = vga_pkg::H_ACTIVE,
  parameter int H_FP       = vga_pkg::H_FP,
  parameter int H_SYNC     = vga_pkg::H_SYNC,
  parameter int H_BP       = vga_pkg::H_BP,
  parameter int V_ACTIVE   = vga_pkg::V_ACTIVE,
  parameter int V_FP       = vga_pkg::V_FP,
  parameter int V_SYNC     = vga_pkg::V_SYNC,
  parameter int V_BP       = vga_pkg::V_BP,
  parameter int PIPE_DELAY = vga_pkg::PIPE_DELAY,
  parameter int FC_W       = vga_pkg::FC_W
) (
  input  logic  vga_clk,
  input  logic  reset,
  vga_if.master vga
);
  import vga_pkg::COORD_W;
  import vga_pkg::vga_sync_t;
  import vga_pkg::SYNC_IDLE;

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_VIS    = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_VIS    = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] HS_FIRST = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS_LAST  = COORD_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [COORD_W-1:0] VS_FIRST = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS_LAST  = COORD_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [COORD_W-1:0] hc;
  logic [COORD_W-1:0] vc;
  logic [COORD_W-1:0] hc_next;
  logic [COORD_W-1:0] vc_next;
  logic               running;
  logic               frame_wrap;
  logic               frame_start;
  logic               vblank_start;
  logic [FC_W-1:0]    frame_count;
  vga_sync_t          sync_next;
  vga_sync_t          sync_now;
  vga_sync_t          sync_pin;

  // Next raster position; the first cycle out of reset stays at the origin.
  always_comb begin
    hc_next    = hc;
    vc_next    = vc;
    frame_wrap = 1'b0;
    if (!running) begin
      hc_next = '0;
      vc_next = '0;
    end else if (hc == H_LAST) begin
      hc_next = '0;
      if (vc == V_LAST) begin
        vc_next    = '0;
        frame_wrap = 1'b1;
      end else begin
        vc_next = vc + COORD_W'(1);
      end
    end else begin
      hc_next = hc + COORD_W'(1);
    end
  end

  // Decode the position being entered so the registered flags line up with DrawX/DrawY.
  always_comb begin
    sync_next.blank = (hc_next < H_VIS) && (vc_next < V_VIS);
    sync_next.hs    = !((hc_next >= HS_FIRST) && (hc_next <= HS_LAST));
    sync_next.vs    = !((vc_next >= VS_FIRST) && (vc_next <= VS_LAST));
  end

  // Counters, undelayed flags, strobes and the completed-frame count.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      hc           <= '0;
      vc           <= '0;
      running      <= 1'b0;
      frame_start  <= 1'b0;
      vblank_start <= 1'b0;
      frame_count  <= '0;
      sync_now     <= SYNC_IDLE;
    end else begin
      hc           <= hc_next;
      vc           <= vc_next;
      running      <= 1'b1;
      frame_start  <= (hc_next == '0) && (vc_next == '0);
      vblank_start <= (hc_next == '0) && (vc_next == V_VIS);
      frame_count  <= frame_wrap ? frame_count + FC_W'(1) : frame_count;
      sync_now     <= sync_next;
    end
  end

  sync_delay #(
    .DEPTH   (PIPE_DELAY),
    .RST_VAL (SYNC_IDLE)
  ) u_sync_delay (
    .clk   (vga_clk),
    .reset (reset),
    .din   (sync_now),
    .dout  (sync_pin)
  );

  assign vga.DrawX        = hc;
  assign vga.DrawY        = vc;
  assign vga.blank        = sync_now.blank;
  assign vga.frame_start  = frame_start;
  assign vga.vblank_start = vblank_start;
  assign vga.frame_count  = frame_count;
  assign vga.hs           = sync_pin.hs;
  assign vga.vs           = sync_pin.vs;
  assign vga.blank_pin    = sync_pin.blank;
endmodule
